// File: rtl/mmio_ctrl.sv
// mmio_ctrl: memory-mapped I/O block on the CPU data bus.
// Decodes a 256-byte window at BASE_ADDR and provides byte-wide output
// registers, a synchronised input port with rising-edge detect, a prescaled
// timer with compare/auto-reload and a maskable interrupt status register.
// Reads are registered with exactly one cycle of latency.
module mmio_ctrl #(
    parameter logic [15:0] BASE_ADDR   = 16'hff00,
    parameter int          NUM_OUT     = 2,
    parameter int          IN_WIDTH    = 8,
    parameter int          TIMER_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   write_enable,
    input  logic                   byte_select,
    input  logic [15:0]            addr,
    input  logic [15:0]            data_in,
    output logic [15:0]            data_out,
    output logic                   serviced_read,
    output logic [8*NUM_OUT-1:0]   gpio_out,
    input  logic [IN_WIDTH-1:0]    gpio_in,
    output logic                   irq
);

    // Register offsets inside the window
    localparam logic [7:0] OFF_IN     = 8'h08;
    localparam logic [7:0] OFF_CNT_LO = 8'h10;
    localparam logic [7:0] OFF_CNT_HI = 8'h11;
    localparam logic [7:0] OFF_CMP_LO = 8'h12;
    localparam logic [7:0] OFF_CMP_HI = 8'h13;
    localparam logic [7:0] OFF_CTRL   = 8'h14;
    localparam logic [7:0] OFF_PRESC  = 8'h15;
    localparam logic [7:0] OFF_STAT   = 8'h18;
    localparam logic [7:0] OFF_MASK   = 8'h19;

    localparam logic [TIMER_WIDTH-1:0] CNT_ONE = TIMER_WIDTH'(1);

    // Address decode: the word address plus the lane bit forms a byte address
    logic [15:0] byte_addr;
    logic [7:0]  offset;
    logic        hit;
    logic        wr_hit;
    logic        rd_hit;
    logic [7:0]  wr_byte;

    assign byte_addr = {addr[14:0], byte_select};
    assign offset    = byte_addr[7:0];
    assign hit       = (byte_addr[15:8] == BASE_ADDR[15:8]);
    assign wr_hit    = en && write_enable && hit;
    assign rd_hit    = en && !write_enable && hit;
    assign wr_byte   = data_in[7:0];

    // addr[15] falls off the byte address and the bus is byte-wide on writes
    logic unused_bits;
    assign unused_bits = &{1'b0, addr[15], data_in[15:8]};

    // ------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------
    logic [NUM_OUT-1:0][15:0] out_rd;
    logic [15:0]              out_rd_any;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_OUT; gi++) begin : g_out
            logic [7:0] out_reg;

            // Each output byte loads on a write hit at its own offset
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    out_reg <= 8'h00;
                end else if (wr_hit && (offset == 8'(gi))) begin
                    out_reg <= wr_byte;
                end
            end

            assign gpio_out[8*gi +: 8] = out_reg;
            assign out_rd[gi] = (offset == 8'(gi)) ? {8'h00, out_reg} : 16'h0000;
        end
    endgenerate

    // At most one output register matches the offset, so OR-combining is a mux
    always_comb begin
        out_rd_any = 16'h0000;
        for (int i = 0; i < NUM_OUT; i++) begin
            out_rd_any = out_rd_any | out_rd[i];
        end
    end

    // ------------------------------------------------------------------
    // Input synchroniser and edge detect
    // ------------------------------------------------------------------
    logic [IN_WIDTH-1:0] sync1_reg;
    logic [IN_WIDTH-1:0] sync2_reg;
    logic                sync3_reg;
    logic                gpio_rise;

    // Two flops to resolve metastability, a third on bit 0 for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
            sync3_reg <= 1'b0;
        end else begin
            sync1_reg <= gpio_in;
            sync2_reg <= sync1_reg;
            sync3_reg <= sync2_reg[0];
        end
    end

    assign gpio_rise = sync2_reg[0] && !sync3_reg;

    // ------------------------------------------------------------------
    // Timer, control and interrupt state
    // ------------------------------------------------------------------
    logic [TIMER_WIDTH-1:0] count_reg, count_next;
    logic [TIMER_WIDTH-1:0] cmp_reg,   cmp_next;
    logic [1:0]             ctrl_reg,  ctrl_next;
    logic [7:0]             presc_reg, presc_next;
    logic [7:0]             pc_reg,    pc_next;
    logic [1:0]             stat_reg,  stat_next;
    logic [1:0]             mask_reg,  mask_next;
    logic [15:0]            count_ext, cmp_ext;
    logic [15:0]            count_wr,  cmp_wr;
    logic                   tick;
    logic                   match;
    logic                   count_write;
    logic [1:0]             stat_clr;

    assign count_ext   = 16'(count_reg);
    assign cmp_ext     = 16'(cmp_reg);
    assign tick        = ctrl_reg[0] && (pc_reg == presc_reg);
    // Compare uses the value before any increment or CPU load this cycle
    assign match       = tick && (count_reg == cmp_reg);
    assign count_write = wr_hit && ((offset == OFF_CNT_LO) || (offset == OFF_CNT_HI));
    assign stat_clr    = (wr_hit && (offset == OFF_STAT)) ? wr_byte[1:0] : 2'b00;

    // Merge the written byte into the current 16-bit view of COUNT and CMP
    always_comb begin
        count_wr = count_ext;
        cmp_wr   = cmp_ext;
        if (offset == OFF_CNT_LO) count_wr[7:0]  = wr_byte;
        if (offset == OFF_CNT_HI) count_wr[15:8] = wr_byte;
        if (offset == OFF_CMP_LO) cmp_wr[7:0]    = wr_byte;
        if (offset == OFF_CMP_HI) cmp_wr[15:8]   = wr_byte;
    end

    // Next-state for timer, prescaler and CPU-writable control registers
    always_comb begin
        count_next = count_reg;
        cmp_next   = cmp_reg;
        ctrl_next  = ctrl_reg;
        presc_next = presc_reg;
        mask_next  = mask_reg;
        pc_next    = 8'h00;

        // A CPU load of COUNT beats a tick: no increment that cycle
        if (count_write) begin
            count_next = count_wr[TIMER_WIDTH-1:0];
        end else if (tick) begin
            count_next = (match && ctrl_reg[1]) ? '0 : count_reg + CNT_ONE;
        end

        // Prescaler free-runs only while the timer is enabled
        if (ctrl_reg[0] && (pc_reg != presc_reg)) begin
            pc_next = pc_reg + 8'h01;
        end

        if (wr_hit) begin
            if ((offset == OFF_CMP_LO) || (offset == OFF_CMP_HI)) cmp_next = cmp_wr[TIMER_WIDTH-1:0];
            if (offset == OFF_CTRL)  ctrl_next  = wr_byte[1:0];
            if (offset == OFF_PRESC) presc_next = wr_byte;
            if (offset == OFF_MASK)  mask_next  = wr_byte[1:0];
        end

        // Hardware set wins over a simultaneous write-one-to-clear
        stat_next = (stat_reg & ~stat_clr) | {gpio_rise, match};
    end

    // State register for timer, control and interrupt status
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
            cmp_reg   <= '0;
            ctrl_reg  <= 2'b00;
            presc_reg <= 8'h00;
            pc_reg    <= 8'h00;
            stat_reg  <= 2'b00;
            mask_reg  <= 2'b00;
        end else begin
            count_reg <= count_next;
            cmp_reg   <= cmp_next;
            ctrl_reg  <= ctrl_next;
            presc_reg <= presc_next;
            pc_reg    <= pc_next;
            stat_reg  <= stat_next;
            mask_reg  <= mask_next;
        end
    end

    assign irq = |(stat_reg & mask_reg);

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    logic [15:0] rd_data;

    // Select the addressed register; unmapped offsets return zero
    always_comb begin
        rd_data = 16'h0000;
        case (offset)
            OFF_IN:     rd_data = 16'(sync2_reg);
            OFF_CNT_LO: rd_data = {8'h00, count_ext[7:0]};
            OFF_CNT_HI: rd_data = {8'h00, count_ext[15:8]};
            OFF_CMP_LO: rd_data = {8'h00, cmp_ext[7:0]};
            OFF_CMP_HI: rd_data = {8'h00, cmp_ext[15:8]};
            OFF_CTRL:   rd_data = {14'h0000, ctrl_reg};
            OFF_PRESC:  rd_data = {8'h00, presc_reg};
            OFF_STAT:   rd_data = {14'h0000, stat_reg};
            OFF_MASK:   rd_data = {14'h0000, mask_reg};
            default:    rd_data = out_rd_any;
        endcase
    end

    // Registered read data, zero when the cycle was not a read in this window
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out      <= 16'h0000;
            serviced_read <= 1'b0;
        end else begin
            data_out      <= rd_hit ? rd_data : 16'h0000;
            serviced_read <= rd_hit;
        end
    end

endmodule

// File: tb/tb_mmio_ctrl.sv
// tb_mmio_ctrl: scenario tasks plus a randomized run checked against an
// integer-level reference model of the register window.
module tb_mmio_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        write_enable = 1'b0;
    logic        byte_select = 1'b0;
    logic [15:0] addr = 16'h0000;
    logic [15:0] data_in = 16'h0000;
    logic [15:0] data_out;
    logic        serviced_read;
    logic [15:0] gpio_out;
    logic [7:0]  gpio_in = 8'h00;
    logic        irq;

    int checks = 0;
    int failures = 0;

    mmio_ctrl #(
        .BASE_ADDR  (16'hff00),
        .NUM_OUT    (2),
        .IN_WIDTH   (8),
        .TIMER_WIDTH(16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .write_enable (write_enable),
        .byte_select  (byte_select),
        .addr         (addr),
        .data_in      (data_in),
        .data_out     (data_out),
        .serviced_read(serviced_read),
        .gpio_out     (gpio_out),
        .gpio_in      (gpio_in),
        .irq          (irq)
    );

    always #5 clk = ~clk;

    // ---------------- reference model (integers, byte-addressed) ----------
    int m_out[2];
    int m_count, m_cmp, m_ctrl, m_presc, m_pc, m_stat, m_mask;
    int m_hist[3];   // gpio_in samples at previous clock edges, [0] = latest
    int m_dout;
    bit m_sr;

    function automatic void model_reset();
        m_out[0] = 0; m_out[1] = 0;
        m_count = 0; m_cmp = 0; m_ctrl = 0; m_presc = 0; m_pc = 0;
        m_stat = 0; m_mask = 0;
        m_hist[0] = 0; m_hist[1] = 0; m_hist[2] = 0;
        m_dout = 0; m_sr = 1'b0;
    endfunction

    function automatic int model_read(input int off);
        case (off)
            'h00: return m_out[0];
            'h01: return m_out[1];
            'h08: return m_hist[1];
            'h10: return m_count & 'hff;
            'h11: return (m_count >> 8) & 'hff;
            'h12: return m_cmp & 'hff;
            'h13: return (m_cmp >> 8) & 'hff;
            'h14: return m_ctrl;
            'h15: return m_presc;
            'h18: return m_stat;
            'h19: return m_mask;
            default: return 0;
        endcase
    endfunction

    function automatic bit model_irq();
        return (m_stat & m_mask) != 0;
    endfunction

    function automatic int model_gpio_out();
        return (m_out[1] << 8) | m_out[0];
    endfunction

    // One clock edge of the window, computed from the pre-edge state
    function automatic void model_step(input bit e, input bit w, input logic [15:0] a,
                                       input logic bs, input int d, input int gin);
        int ba, off, new_stat;
        bit hit, wr, rd, run, tick, match, rise;
        ba   = ((int'(a) & 'h7fff) << 1) | int'(bs);
        hit  = ((ba >> 8) == 'hff);
        off  = ba & 'hff;
        wr   = e && w && hit;
        rd   = e && !w && hit;
        run  = (m_ctrl & 1) != 0;
        tick = run && (m_pc == m_presc);
        match = tick && (m_count == m_cmp);
        rise = ((m_hist[1] & 1) == 1) && ((m_hist[2] & 1) == 0);

        m_dout = rd ? model_read(off) : 0;
        m_sr   = rd;

        new_stat = m_stat;
        if (wr && off == 'h18) new_stat = new_stat & ~(d & 3);
        if (match) new_stat = new_stat | 1;
        if (rise)  new_stat = new_stat | 2;

        if (wr && off == 'h10)      m_count = (m_count & 'hff00) | d;
        else if (wr && off == 'h11) m_count = (m_count & 'h00ff) | (d << 8);
        else if (tick)              m_count = (match && (m_ctrl & 2) != 0) ? 0 : (m_count + 1) % 65536;

        if (!run || m_pc == m_presc) m_pc = 0;
        else                         m_pc = m_pc + 1;

        if (wr) begin
            case (off)
                'h00: m_out[0] = d;
                'h01: m_out[1] = d;
                'h12: m_cmp = (m_cmp & 'hff00) | d;
                'h13: m_cmp = (m_cmp & 'h00ff) | (d << 8);
                'h14: m_ctrl = d & 3;
                'h15: m_presc = d;
                'h19: m_mask = d & 3;
                default: ;
            endcase
        end
        m_stat = new_stat;

        m_hist[2] = m_hist[1];
        m_hist[1] = m_hist[0];
        m_hist[0] = gin;
    endfunction

    // ---------------- bus helpers -------------------------------------------
    // One bus cycle at byte address ba; returns 1 time unit after the edge
    task automatic bus(input bit e, input bit w, input logic [15:0] ba, input logic [7:0] d);
        logic [15:0] junk;
        @(negedge clk);
        junk = 16'($urandom);
        en           = e;
        write_enable = w;
        byte_select  = ba[0];
        addr         = {junk[0], ba[15:1]};
        data_in      = {junk[15:8], d};
        @(posedge clk);
        model_step(e, w, addr, byte_select, int'(d), int'(gpio_in));
        #1;
        if (e) $display("txn t=%0t %s ba=%h d=%h data_out=%h sr=%0b irq=%0b",
                        $time, w ? "WR" : "RD", ba, d, data_out, serviced_read, irq);
    endtask

    task automatic wr_reg(input logic [7:0] off, input logic [7:0] d);
        bus(1'b1, 1'b1, 16'hff00 | 16'(off), d);
    endtask

    task automatic rd_reg(input logic [7:0] off);
        bus(1'b1, 1'b0, 16'hff00 | 16'(off), 8'h00);
    endtask

    task automatic idle();
        bus(1'b0, 1'b0, 16'h0000, 8'h00);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        en = 1'b0;
        write_enable = 1'b0;
        gpio_in = 8'h00;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // ---------------- scenarios ---------------------------------------------
    task automatic test_reset();
        do_reset();
        checks++; if (gpio_out !== 16'h0000) begin failures++; $display("FAIL reset_gpio_out got=%h exp=0000", gpio_out); end
        checks++; if (data_out !== 16'h0000) begin failures++; $display("FAIL reset_data_out got=%h exp=0000", data_out); end
        checks++; if (serviced_read !== 1'b0) begin failures++; $display("FAIL reset_sr got=%b exp=0", serviced_read); end
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", irq); end
        rd_reg(8'h14);
        checks++; if (data_out !== 16'h0000) begin failures++; $display("FAIL reset_ctrl_read got=%h exp=0000", data_out); end
        checks++; if (serviced_read !== 1'b1) begin failures++; $display("FAIL reset_ctrl_sr got=%b exp=1", serviced_read); end
    endtask

    task automatic test_gpio_out();
        do_reset();
        wr_reg(8'h01, 8'hA5);
        checks++; if (gpio_out[15:8] !== 8'hA5) begin failures++; $display("FAIL gpio_out_hi got=%h exp=a5", gpio_out[15:8]); end
        rd_reg(8'h01);
        checks++; if (data_out !== 16'h00A5) begin failures++; $display("FAIL gpio_read got=%h exp=00a5", data_out); end
        checks++; if (serviced_read !== 1'b1) begin failures++; $display("FAIL gpio_read_sr got=%b exp=1", serviced_read); end
        bus(1'b1, 1'b0, 16'hfe00, 8'h00);
        checks++; if (serviced_read !== 1'b0) begin failures++; $display("FAIL miss_sr got=%b exp=0", serviced_read); end
        checks++; if (data_out !== 16'h0000) begin failures++; $display("FAIL miss_data got=%h exp=0000", data_out); end
    endtask

    task automatic test_timer_autoreload();
        do_reset();
        wr_reg(8'h12, 8'h03);
        wr_reg(8'h13, 8'h00);
        wr_reg(8'h15, 8'h01);
        wr_reg(8'h19, 8'h01);
        wr_reg(8'h14, 8'h03);
        // Each read returns COUNT as it was before that edge: 0,0,1,1,2,2,3,3,0,...
        for (int i = 1; i <= 16; i++) begin
            rd_reg(8'h10);
            checks++; if (data_out !== 16'(((i - 1) / 2) % 4)) begin failures++; $display("FAIL autoreload_count i=%0d got=%h exp=%h", i, data_out, 16'(((i - 1) / 2) % 4)); end
            checks++; if (irq !== (i >= 8)) begin failures++; $display("FAIL autoreload_irq i=%0d got=%b exp=%b", i, irq, (i >= 8)); end
        end
        wr_reg(8'h14, 8'h00);
        checks++; if (irq !== 1'b1) begin failures++; $display("FAIL autoreload_irq_held got=%b exp=1", irq); end
        wr_reg(8'h18, 8'h01);
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL autoreload_w1c got=%b exp=0", irq); end
    endtask

    task automatic test_wrap();
        do_reset();
        wr_reg(8'h10, 8'hff);
        wr_reg(8'h11, 8'hff);
        wr_reg(8'h12, 8'h05);
        wr_reg(8'h19, 8'h01);
        wr_reg(8'h14, 8'h01);
        for (int i = 1; i <= 7; i++) begin
            rd_reg(8'h10);
            checks++; if (data_out !== ((i == 1) ? 16'h00ff : 16'(i - 2))) begin failures++; $display("FAIL wrap_count i=%0d got=%h", i, data_out); end
            checks++; if (irq !== (i == 7)) begin failures++; $display("FAIL wrap_irq i=%0d got=%b exp=%b", i, irq, (i == 7)); end
        end
        rd_reg(8'h11);
        checks++; if (data_out !== 16'h0000) begin failures++; $display("FAIL wrap_count_hi got=%h exp=0000", data_out); end
    endtask

    task automatic test_collision();
        // COUNT load in a tick cycle: loaded value, no increment
        do_reset();
        wr_reg(8'h14, 8'h01);
        idle();
        idle();
        wr_reg(8'h10, 8'h40);
        rd_reg(8'h10);
        checks++; if (data_out !== 16'h0040) begin failures++; $display("FAIL collide_count got=%h exp=0040", data_out); end
        rd_reg(8'h11);
        checks++; if (data_out !== 16'h0000) begin failures++; $display("FAIL collide_count_hi got=%h exp=0000", data_out); end
        // W1C of bit0 in the match cycle: set wins
        do_reset();
        wr_reg(8'h12, 8'h03);
        wr_reg(8'h19, 8'h01);
        wr_reg(8'h14, 8'h01);
        idle();
        idle();
        idle();
        wr_reg(8'h18, 8'h01);
        checks++; if (irq !== 1'b1) begin failures++; $display("FAIL collide_w1c_irq got=%b exp=1", irq); end
        rd_reg(8'h18);
        checks++; if (data_out !== 16'h0001) begin failures++; $display("FAIL collide_w1c_stat got=%h exp=0001", data_out); end
        // COUNT load in the match cycle: match uses the pre-write value
        do_reset();
        wr_reg(8'h12, 8'h02);
        wr_reg(8'h19, 8'h01);
        wr_reg(8'h14, 8'h01);
        idle();
        idle();
        wr_reg(8'h10, 8'h80);
        checks++; if (irq !== 1'b1) begin failures++; $display("FAIL collide_prewrite_irq got=%b exp=1", irq); end
        rd_reg(8'h10);
        checks++; if (data_out !== 16'h0080) begin failures++; $display("FAIL collide_prewrite_count got=%h exp=0080", data_out); end
    endtask

    task automatic test_edge_irq();
        do_reset();
        wr_reg(8'h19, 8'h02);
        gpio_in = 8'h01;
        for (int i = 1; i <= 3; i++) begin
            idle();
            checks++; if (irq !== (i == 3)) begin failures++; $display("FAIL edge_irq i=%0d got=%b exp=%b", i, irq, (i == 3)); end
        end
        rd_reg(8'h08);
        checks++; if (data_out !== 16'h0001) begin failures++; $display("FAIL edge_in_read got=%h exp=0001", data_out); end
        wr_reg(8'h18, 8'h02);
        for (int i = 0; i < 5; i++) idle();
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL edge_rearm got=%b exp=0", irq); end
        rd_reg(8'h18);
        checks++; if (data_out !== 16'h0000) begin failures++; $display("FAIL edge_stat got=%h exp=0000", data_out); end
    endtask

    task automatic test_async_reset();
        do_reset();
        wr_reg(8'h00, 8'h5a);
        wr_reg(8'h19, 8'h01);
        wr_reg(8'h14, 8'h01);
        idle();
        checks++; if (irq !== 1'b1) begin failures++; $display("FAIL async_pre_irq got=%b exp=1", irq); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL async_irq got=%b exp=0", irq); end
        checks++; if (gpio_out !== 16'h0000) begin failures++; $display("FAIL async_gpio got=%h exp=0000", gpio_out); end
        checks++; if (data_out !== 16'h0000) begin failures++; $display("FAIL async_data got=%h exp=0000", data_out); end
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_random();
        logic [7:0]  offs [14];
        logic [7:0]  off;
        logic [7:0]  d;
        logic [15:0] ba;
        bit          e, w;
        offs = '{8'h00, 8'h01, 8'h02, 8'h08, 8'h10, 8'h11, 8'h12,
                 8'h13, 8'h14, 8'h15, 8'h18, 8'h19, 8'h1a, 8'hff};
        do_reset();
        for (int i = 0; i < 400; i++) begin
            off = offs[$urandom_range(0, 13)];
            d   = 8'($urandom);
            if (off == 8'h15) d = d & 8'h03;
            if (off == 8'h11 || off == 8'h13) d = d & 8'h01;
            if ($urandom_range(0, 7) == 0) begin
                ba = 16'($urandom);
                if (ba[15:8] == 8'hff) ba[15] = 1'b0;
            end else begin
                ba = 16'hff00 | 16'(off);
            end
            e = ($urandom_range(0, 3) != 0);
            w = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 5) == 0) gpio_in = 8'($urandom);
            bus(e, w, ba, d);
            checks++; if (data_out !== 16'(m_dout)) begin failures++; $display("FAIL rand_data i=%0d got=%h exp=%h", i, data_out, 16'(m_dout)); end
            checks++; if (serviced_read !== m_sr) begin failures++; $display("FAIL rand_sr i=%0d got=%b exp=%b", i, serviced_read, m_sr); end
            checks++; if (irq !== model_irq()) begin failures++; $display("FAIL rand_irq i=%0d got=%b exp=%b", i, irq, model_irq()); end
            checks++; if (gpio_out !== 16'(model_gpio_out())) begin failures++; $display("FAIL rand_gpio i=%0d got=%h exp=%h", i, gpio_out, 16'(model_gpio_out())); end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_gpio_out();
        test_timer_autoreload();
        test_wrap();
        test_collision();
        test_edge_irq();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
